// File: rtl/pipe_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_if : decode-stage hazard signals between pipeline and controller. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface pipe_hazard_ctrl_if #(
   parameter int CNT_W = 16
);
   logic             id_valid;
   logic [4:0]       id_rs;
   logic [4:0]       id_rt;
   logic             id_use_rs;
   logic             id_use_rt;
   logic             id_wreg;
   logic             id_m2reg;
   logic [4:0]       id_rn;
   logic [1:0]       id_pcsource;
   logic             mem_busy;
   logic             wpcir;
   logic             ex_bubble;
   logic             flush_ifid;
   logic [1:0]       fwda;
   logic [1:0]       fwdb;
   logic             freeze;
   logic [CNT_W-1:0] stall_cnt;

   modport master (
      output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wreg, id_m2reg,
             id_rn, id_pcsource, mem_busy,
      input  wpcir, ex_bubble, flush_ifid, fwda, fwdb, freeze, stall_cnt
   );

   modport slave (
      input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wreg, id_m2reg,
             id_rn, id_pcsource, mem_busy,
      output wpcir, ex_bubble, flush_ifid, fwda, fwdb, freeze, stall_cnt
   );
endinterface

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl : forwarding, load-use stall, flush and freeze control. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pipe_hazard_ctrl #(
   parameter int CNT_W = 16
) (
   input  wire logic         clk,
   input  wire logic         clrn,
   pipe_hazard_ctrl_if.slave hz
);
   logic             ex_wreg, ex_m2reg, mem_wreg, mem_m2reg;
   logic [4:0]       ex_rn, mem_rn;
   logic [CNT_W-1:0] cnt;

   logic ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt;
   logic lu, frz;

   assign ex_hit_rs  = ex_wreg  && (ex_rn  != 5'd0) && (ex_rn  == hz.id_rs);
   assign ex_hit_rt  = ex_wreg  && (ex_rn  != 5'd0) && (ex_rn  == hz.id_rt);
   assign mem_hit_rs = mem_wreg && (mem_rn != 5'd0) && (mem_rn == hz.id_rs);
   assign mem_hit_rt = mem_wreg && (mem_rn != 5'd0) && (mem_rn == hz.id_rt);

   assign lu  = hz.id_valid && ex_m2reg &&
                ((hz.id_use_rs && ex_hit_rs) || (hz.id_use_rt && ex_hit_rt));
   assign frz = hz.mem_busy;

   // Freeze dominates the load-use interlock and any flush.
   assign hz.freeze     = frz;
   assign hz.wpcir      = !frz && !lu;
   assign hz.ex_bubble  = !frz && lu;
   assign hz.flush_ifid = hz.id_valid && !lu && !frz && (hz.id_pcsource != 2'b00);
   assign hz.stall_cnt  = cnt;

   always_comb begin
      hz.fwda = 2'b00;
      if (hz.id_use_rs) begin
         if (ex_hit_rs)       hz.fwda = 2'b01;
         else if (mem_hit_rs) hz.fwda = mem_m2reg ? 2'b11 : 2'b10;
      end
   end

   always_comb begin
      hz.fwdb = 2'b00;
      if (hz.id_use_rt) begin
         if (ex_hit_rt)       hz.fwdb = 2'b01;
         else if (mem_hit_rt) hz.fwdb = mem_m2reg ? 2'b11 : 2'b10;
      end
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         ex_wreg   <= 1'b0;
         ex_m2reg  <= 1'b0;
         ex_rn     <= 5'd0;
         mem_wreg  <= 1'b0;
         mem_m2reg <= 1'b0;
         mem_rn    <= 5'd0;
         cnt       <= '0;
      end else if (!frz) begin
         mem_wreg  <= ex_wreg;
         mem_m2reg <= ex_m2reg;
         mem_rn    <= ex_rn;
         // A bubble or an interlocked instruction enters EX as a NOP.
         ex_wreg   <= hz.id_valid && !lu && hz.id_wreg;
         ex_m2reg  <= hz.id_valid && !lu && hz.id_m2reg;
         ex_rn     <= hz.id_rn;
         if (lu && (cnt != {CNT_W{1'b1}})) cnt <= cnt + 1'b1;
      end
   end
endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl : directed self-checking bench for pipe_hazard_ctrl. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pipe_hazard_ctrl;
   logic clk = 1'b0;
   logic clrn = 1'b0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl_if #(.CNT_W(16)) hz ();
   pipe_hazard_ctrl_if #(.CNT_W(2))  hs ();

   pipe_hazard_ctrl #(.CNT_W(16)) dut   (.clk(clk), .clrn(clrn), .hz(hz));
   pipe_hazard_ctrl #(.CNT_W(2))  dut_s (.clk(clk), .clrn(clrn), .hz(hs));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drv(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                      input logic urs, input logic urt, input logic w, input logic m,
                      input logic [4:0] rn, input logic [1:0] pc);
      hz.id_valid = v;   hz.id_rs = rs;   hz.id_rt = rt;
      hz.id_use_rs = urs; hz.id_use_rt = urt;
      hz.id_wreg = w;    hz.id_m2reg = m; hz.id_rn = rn; hz.id_pcsource = pc;
   endtask

   task automatic drv_s(input logic v, input logic [4:0] rt, input logic urt,
                        input logic w, input logic m, input logic [4:0] rn);
      hs.id_valid = v;   hs.id_rs = 5'd0; hs.id_rt = rt;
      hs.id_use_rs = 1'b0; hs.id_use_rt = urt;
      hs.id_wreg = w;    hs.id_m2reg = m; hs.id_rn = rn; hs.id_pcsource = 2'b00;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      drv(0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
      drv_s(0, 0, 0, 0, 0, 0);
      hz.mem_busy = 1'b0;
      hs.mem_busy = 1'b0;

      // Reset state
      @(negedge clk);
      chk("rst_wpcir", hz.wpcir, 1);
      chk("rst_bubble", hz.ex_bubble, 0);
      chk("rst_flush", hz.flush_ifid, 0);
      chk("rst_fwda", hz.fwda, 0);
      chk("rst_fwdb", hz.fwdb, 0);
      chk("rst_freeze", hz.freeze, 0);
      chk("rst_cnt", hz.stall_cnt, 0);
      hz.mem_busy = 1'b1;
      #1 chk("rst_freeze_busy", hz.freeze, 1);
      hz.mem_busy = 1'b0;
      #1 clrn = 1'b1;
      tick();

      // add r3 ; sub reads r3 (EX fwd) ; or reads r3 (MEM ALU fwd)
      drv(1, 1, 2, 1, 1, 1, 0, 3, 2'b00);
      @(negedge clk); chk("empty_fwda", hz.fwda, 0);
      tick();
      drv(1, 3, 4, 1, 1, 1, 0, 6, 2'b00);
      @(negedge clk);
      chk("ex_fwda", hz.fwda, 1);
      chk("ex_fwdb", hz.fwdb, 0);
      chk("ex_wpcir", hz.wpcir, 1);
      tick();
      drv(1, 3, 3, 1, 1, 0, 0, 0, 2'b00);
      @(negedge clk);
      chk("mem_fwda", hz.fwda, 2);
      chk("mem_fwdb", hz.fwdb, 2);
      tick();

      // lw r5 ; add reads rt=r5 -> one stall, then load-data forward
      drv(1, 9, 0, 1, 0, 1, 1, 5, 2'b00);
      @(negedge clk); chk("lw_fwda", hz.fwda, 0);
      tick();
      drv(1, 1, 5, 1, 1, 1, 0, 8, 2'b00);
      @(negedge clk);
      chk("lu_wpcir", hz.wpcir, 0);
      chk("lu_bubble", hz.ex_bubble, 1);
      chk("lu_cnt_before", hz.stall_cnt, 0);
      tick();
      @(negedge clk);
      chk("lu2_wpcir", hz.wpcir, 1);
      chk("lu2_bubble", hz.ex_bubble, 0);
      chk("lu2_fwdb", hz.fwdb, 3);
      chk("lu2_cnt", hz.stall_cnt, 1);
      tick();

      // add r0 ; reader of r0 (also writes r7) ; j with unused rs=r7
      drv(1, 1, 2, 1, 1, 1, 0, 0, 2'b00);
      tick();
      drv(1, 0, 2, 1, 0, 1, 0, 7, 2'b00);
      @(negedge clk); chk("r0_fwda", hz.fwda, 0);
      tick();
      drv(1, 7, 0, 0, 0, 0, 0, 0, 2'b11);
      @(negedge clk);
      chk("unused_fwda", hz.fwda, 0);
      chk("j_flush", hz.flush_ifid, 1);
      tick();
      drv(0, 0, 0, 0, 0, 0, 0, 0, 2'b01);
      @(negedge clk); chk("inval_flush", hz.flush_ifid, 0);
      tick();
      drv(1, 20, 21, 1, 1, 0, 0, 0, 2'b01);
      @(negedge clk); chk("br_flush", hz.flush_ifid, 1);
      tick();

      // Freeze over a pending load-use
      drv(1, 0, 0, 0, 0, 1, 1, 10, 2'b00);
      tick();
      drv(1, 10, 0, 1, 0, 1, 0, 11, 2'b01);
      hz.mem_busy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("frz_freeze", hz.freeze, 1);
         chk("frz_bubble", hz.ex_bubble, 0);
         chk("frz_wpcir", hz.wpcir, 0);
         chk("frz_flush", hz.flush_ifid, 0);
         chk("frz_cnt", hz.stall_cnt, 1);
         tick();
      end
      hz.mem_busy = 1'b0;
      @(negedge clk);
      chk("unfrz_bubble", hz.ex_bubble, 1);
      chk("unfrz_flush", hz.flush_ifid, 0);
      tick();
      @(negedge clk);
      chk("unfrz_cnt", hz.stall_cnt, 2);
      chk("unfrz_fwda", hz.fwda, 3);
      chk("unfrz_flush2", hz.flush_ifid, 1);
      tick();

      // Reset asserted in the middle of a stall
      drv(1, 0, 0, 0, 0, 1, 1, 12, 2'b00);
      tick();
      drv(1, 12, 0, 1, 0, 0, 0, 0, 2'b00);
      @(negedge clk);
      chk("pre_rst_bubble", hz.ex_bubble, 1);
      #1 clrn = 1'b0;
      #1;
      chk("mid_rst_wpcir", hz.wpcir, 1);
      chk("mid_rst_bubble", hz.ex_bubble, 0);
      chk("mid_rst_fwda", hz.fwda, 0);
      chk("mid_rst_cnt", hz.stall_cnt, 0);
      clrn = 1'b1;
      #1 chk("post_rst_wpcir", hz.wpcir, 1);
      tick();

      // Saturation of a 2-bit counter over 5 stalls
      for (int k = 0; k < 5; k++) begin
         drv_s(1, 0, 0, 1, 1, 5);
         tick();
         drv_s(1, 5, 1, 1, 0, 6);
         @(negedge clk); chk("sat_bubble", hs.ex_bubble, 1);
         tick();
         tick();
         @(negedge clk);
         chk("sat_cnt", hs.stall_cnt, (k < 3) ? k + 1 : 3);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and interlock controller for the five-stage pipelined CPU. Sits beside the decode stage. Each cycle it compares the decoded source registers against its own registered record of the instructions in EX and MEM. From that it drives:
- operand-forwarding selects for the decode-stage `a`/`b` multiplexers,
- the load-use stall (PC and IF/ID write enable, EX bubble),
- the IF/ID flush on taken control transfers,
- a whole-pipeline freeze when data memory is busy.

## Interface
Parameters:
- `CNT_W`, default 16: width of the saturating stall-cycle counter.

Ports:
- `clk`  in  1: clock, all state updates on rising edge.
- `clrn`  in  1: asynchronous, active-low reset.
- `id_valid`  in  1: IF/ID holds a real instruction (0 = bubble).
- `id_rs`, `id_rt`  in  5 each: decoded source register numbers.
- `id_use_rs`, `id_use_rt`  in  1 each: instruction actually reads that source.
- `id_wreg`, `id_m2reg`  in  1 each: decoded register write and load flags.
- `id_rn`  in  5: decoded destination register.
- `id_pcsource`  in  2: next-PC select. 00 = pc4, 01 = bpc, 10 = register jump, 11 = jpc.
- `mem_busy`  in  1: data memory cannot complete this cycle.
- `wpcir`  out  1: PC and IF/ID write enable (1 = advance).
- `ex_bubble`  out  1: ID/EX register must load a NOP (wreg = wmem = 0).
- `flush_ifid`  out  1: IF/ID loads a bubble (id_valid = 0) at the next edge.
- `fwda`, `fwdb`  out  2 each: operand source. 00 = regfile, 01 = EX ALU result, 10 = MEM ALU result, 11 = MEM load data.
- `freeze`  out  1: all pipeline registers hold.
- `stall_cnt`  out  CNT_W: saturating count of load-use stall cycles.

## Operation
- **Shadow state.** Registered copies of the instructions in EX and MEM: `ex_wreg`, `ex_m2reg`, `ex_rn`, `mem_wreg`, `mem_m2reg`, `mem_rn`.
- **Shadow update each unfrozen edge:**
  - MEM <- EX.
  - EX <- decoded ID fields, gated by `id_valid & ~ex_bubble`. When gated off, the EX copy gets `wreg` = 0.
- **Match definitions.**
  - `ex_hit(r)` = `ex_wreg & ex_rn != 0 & ex_rn == r`.
  - `mem_hit(r)` is the same test on the MEM copy.
  - Register 0 never matches.
- **Forward select per source (rs -> `fwda`, rt -> `fwdb`).**
  - If the source is unused: 00.
  - Else if `ex_hit`: 01.
  - Else if `mem_hit`: 11 when `mem_m2reg`, otherwise 10.
  - Else: 00.
  - EX takes priority over MEM.
- **Load-use stall.** `lu = id_valid & ((id_use_rs & ex_hit(rs)) | (id_use_rt & ex_hit(rt))) & ex_m2reg`.
  - When `lu`: `wpcir` = 0 and `ex_bubble` = 1.
  - `fwda`/`fwdb` are don't-care while `lu` holds.
- **Control flush.** `flush_ifid = id_valid & ~lu & ~freeze & (id_pcsource != 00)`.
  - There is no delay slot; the wrong-path instruction is discarded.
  - A branch whose operand depends on an EX load stalls first and flushes one cycle later.
- **Freeze.** `freeze = mem_busy`.
  - While frozen: `wpcir` = 0, `ex_bubble` = 0, `flush_ifid` = 0.
  - Shadow state and `stall_cnt` hold.
  - Freeze dominates `lu`.
- **Stall counter.** `stall_cnt` increments on each edge where `lu & ~freeze`, and saturates at all-ones.

## Timing
- `wpcir`, `ex_bubble`, `flush_ifid`, `fwda`, `fwdb` and `freeze` are combinational from ID inputs, shadow state and `mem_busy`. They are valid in the same cycle; there is no added latency.
- A load-use stall lasts exactly one cycle. On the next edge the load moves to MEM and the consumer receives `fwd` = 11.
- **Reset (`clrn` = 0, asynchronous):**
  - All shadow `wreg`/`m2reg` = 0 and `rn` = 0; `stall_cnt` = 0.
  - Outputs therefore read `wpcir` = 1, `ex_bubble` = 0, `flush_ifid` = 0, `fwda` = `fwdb` = 00, and `freeze` = `mem_busy`.
- Reset asserted mid-stall clears everything immediately. The first cycle after release behaves as an empty pipeline.
- When `mem_busy` deasserts, the cycle resumes exactly where it was frozen. Any pending `lu` or flush is re-evaluated from the held state.

## Test plan
- **EX forward.** Cycle 0 ID: `add r3`; cycle 1 ID: `sub` reading rs = r3 -> `fwda` = 01, `wpcir` = 1. Cycle 2 -> `fwda` = 10.
- **Load-use.** Cycle 0: `lw r5` (`m2reg` = 1); cycle 1: `add` reading rt = r5 -> `wpcir` = 0 and `ex_bubble` = 1 for one cycle. Next cycle `fwdb` = 11; `stall_cnt` = 1.
- **r0 and unused sources.** `add r0` followed by a reader of r0 -> `fwda` = 00. Writer r7 followed by `j`, which has `id_use_rs` = 0 while rs field = r7 -> `fwda` = 00.
- **Taken branch.** `id_pcsource` = 01 with `id_valid` = 1 and no hazard -> `flush_ifid` = 1 for one cycle. With `id_valid` = 0 -> 0.
- **Freeze over load-use.** Hold `mem_busy` = 1 for 3 cycles while a load-use condition is present -> `freeze` = 1, `ex_bubble` = 0, `stall_cnt` unchanged. After release, one stall cycle occurs and `stall_cnt` increments.
- **Reset and saturation.** Assert `clrn` = 0 mid-stall -> outputs go immediately to reset values. Separately, with `CNT_W` = 2, apply 5 stall cycles -> `stall_cnt` = 3.
